// File: rtl/fll_trim_controller.sv
// FLL trim controller: measures DCO cycles per reference period and steps a
// saturating binary trim code toward `div`, driving a thermometer trim bus.
module fll_trim_controller #(
  parameter int DIV_WIDTH  = 5,
  parameter int TRIM_WIDTH = 26,
  parameter int CODE_WIDTH = 5,
  parameter int CNT_WIDTH  = 8,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4,
  parameter int INIT_CODE  = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  osc,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [1:0]            mode,
  input  logic [TRIM_WIDTH-1:0] ext_trim,
  output logic [TRIM_WIDTH-1:0] trim,
  output logic [CODE_WIDTH-1:0] trim_code,
  output logic                  locked,
  output logic                  ref_lost,
  output logic [CNT_WIDTH-1:0]  count_last
);

  localparam int STREAK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;
  localparam logic signed [CNT_WIDTH:0] TOL_S  = (CNT_WIDTH + 1)'(TOL);
  localparam logic [CODE_WIDTH-1:0] CODE_MAX   = CODE_WIDTH'(TRIM_WIDTH);
  localparam logic [CODE_WIDTH-1:0] CODE_INIT  = CODE_WIDTH'(INIT_CODE);
  localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(LOCK_COUNT);

  logic                  osc_meta_q, osc_meta_d;
  logic                  osc_sync_q, osc_sync_d;
  logic                  osc_prev_q, osc_prev_d;
  logic                  ref_edge_q, ref_edge_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  count_last_q, count_last_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  locked_q, locked_d;
  logic                  ref_lost_q, ref_lost_d;
  logic                  first_q, first_d;
  logic [TRIM_WIDTH-1:0] trim_q, trim_d;

  logic [TRIM_WIDTH-1:0] therm;
  logic [TRIM_WIDTH-1:0] therm_init;
  logic signed [CNT_WIDTH:0] err;

  genvar gi;
  generate
    for (gi = 0; gi < TRIM_WIDTH; gi++) begin : g_therm
      assign therm[gi]      = (code_q > CODE_WIDTH'(gi));
      assign therm_init[gi] = (CODE_INIT > CODE_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    osc_meta_d   = osc;
    osc_sync_d   = osc_meta_q;
    osc_prev_d   = osc_sync_q;
    ref_edge_d   = osc_sync_q & ~osc_prev_q;
    cnt_d        = cnt_q;
    count_last_d = count_last_q;
    code_d       = code_q;
    streak_d     = streak_q;
    locked_d     = locked_q;
    ref_lost_d   = ref_lost_q;
    first_d      = first_q;
    trim_d       = (mode == 2'b01) ? ext_trim : therm;

    err = $signed({1'b0, cnt_q}) -
          $signed({{(CNT_WIDTH + 1 - DIV_WIDTH){1'b0}}, div});

    if (!enable) begin
      cnt_d      = '0;
      streak_d   = '0;
      locked_d   = 1'b0;
      ref_lost_d = 1'b0;
      first_d    = 1'b1;
    end else if (ref_edge_q) begin
      // An edge always restarts the period, even when the counter saturated.
      cnt_d = CNT_WIDTH'(1);
      if (first_q) begin
        first_d    = 1'b0;
        ref_lost_d = 1'b0;
      end else begin
        count_last_d = cnt_q;
        if (div < DIV_WIDTH'(2)) begin
          streak_d = '0;
          locked_d = 1'b0;
        end else if (err > TOL_S) begin
          streak_d = '0;
          locked_d = 1'b0;
          if (mode == 2'b00 && code_q < CODE_MAX) code_d = code_q + CODE_WIDTH'(1);
        end else if (err < -TOL_S) begin
          streak_d = '0;
          locked_d = 1'b0;
          if (mode == 2'b00 && code_q != '0) code_d = code_q - CODE_WIDTH'(1);
        end else begin
          if (streak_q != STREAK_MAX) streak_d = streak_q + STREAK_W'(1);
          locked_d = (streak_d == STREAK_MAX);
        end
      end
    end else begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      // Saturated counter with no edge: reference considered lost, re-arm.
      if (cnt_q == CNT_MAX) begin
        ref_lost_d = 1'b1;
        streak_d   = '0;
        locked_d   = 1'b0;
        first_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      osc_meta_q   <= 1'b0;
      osc_sync_q   <= 1'b0;
      osc_prev_q   <= 1'b0;
      ref_edge_q   <= 1'b0;
      cnt_q        <= '0;
      count_last_q <= '0;
      code_q       <= CODE_INIT;
      streak_q     <= '0;
      locked_q     <= 1'b0;
      ref_lost_q   <= 1'b0;
      first_q      <= 1'b1;
      trim_q       <= therm_init;
    end else begin
      osc_meta_q   <= osc_meta_d;
      osc_sync_q   <= osc_sync_d;
      osc_prev_q   <= osc_prev_d;
      ref_edge_q   <= ref_edge_d;
      cnt_q        <= cnt_d;
      count_last_q <= count_last_d;
      code_q       <= code_d;
      streak_q     <= streak_d;
      locked_q     <= locked_d;
      ref_lost_q   <= ref_lost_d;
      first_q      <= first_d;
      trim_q       <= trim_d;
    end
  end

  assign trim       = trim_q;
  assign trim_code  = code_q;
  assign locked     = locked_q;
  assign ref_lost   = ref_lost_q;
  assign count_last = count_last_q;

endmodule

// File: tb/tb_fll_trim_controller.sv
// Directed bench for fll_trim_controller: timestamp-based reference model checked
// every cycle, plus literal expectations at the end of each scenario.
module tb_fll_trim_controller;

  logic        clock = 1'b0;
  logic        reset, enable, osc;
  logic [4:0]  div;
  logic [1:0]  mode;
  logic [25:0] ext_trim;
  logic [25:0] trim;
  logic [4:0]  trim_code;
  logic        locked, ref_lost;
  logic [7:0]  count_last;

  fll_trim_controller dut (
    .clock(clock), .reset(reset), .enable(enable), .osc(osc), .div(div),
    .mode(mode), .ext_trim(ext_trim), .trim(trim), .trim_code(trim_code),
    .locked(locked), .ref_lost(ref_lost), .count_last(count_last)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int fail_prints = 0;

  task automatic chk(input string name, input longint act, input longint exp, input bit verbose);
    total++;
    if (act != exp) begin
      bad++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
    end else if (verbose) begin
      $display("check %s: got %0h ok", name, act);
    end
  endtask

  function automatic logic [25:0] therm(input int c);
    logic [63:0] v;
    v = (64'd1 << c) - 64'd1;
    return v[25:0];
  endfunction

  // Reference model: counter value is derived from the cycle of the last restart.
  int          m_t = 0;
  int          m_o = 0;
  int          m_code = 13;
  int          m_streak = 0;
  int          m_count_last = 0;
  bit          m_locked = 0, m_ref_lost = 0, m_first = 1, m_osc_prev = 0, m_valid = 0;
  logic [25:0] m_trim = '0;
  int          pend[$];

  always @(posedge clock) begin
    int cnt_old;
    int err;
    bit got_edge;
    m_t++;
    if (reset) begin
      m_code = 13; m_streak = 0; m_count_last = 0;
      m_locked = 0; m_ref_lost = 0; m_first = 1; m_osc_prev = 0;
      m_trim = therm(13); m_o = m_t; m_valid = 1;
      pend.delete();
    end else begin
      m_trim = (mode == 2'b01) ? ext_trim : therm(m_code);
      got_edge = (pend.size() > 0 && pend[0] == m_t);
      if (got_edge) void'(pend.pop_front());
      if (osc && !m_osc_prev) pend.push_back(m_t + 3);
      m_osc_prev = osc;
      cnt_old = m_t - 1 - m_o;
      if (cnt_old > 255) cnt_old = 255;
      if (!enable) begin
        m_streak = 0; m_locked = 0; m_ref_lost = 0; m_first = 1; m_o = m_t;
      end else if (got_edge) begin
        if (m_first) begin
          m_first = 0; m_ref_lost = 0;
        end else begin
          m_count_last = cnt_old;
          err = cnt_old - int'(div);
          if (div < 2) begin
            m_streak = 0; m_locked = 0;
          end else if (err > 1) begin
            m_streak = 0; m_locked = 0;
            if (mode == 2'b00 && m_code < 26) m_code++;
          end else if (err < -1) begin
            m_streak = 0; m_locked = 0;
            if (mode == 2'b00 && m_code > 0) m_code--;
          end else begin
            if (m_streak < 4) m_streak++;
            m_locked = (m_streak == 4);
          end
        end
        m_o = m_t - 1;
      end else if (cnt_old == 255) begin
        m_ref_lost = 1; m_streak = 0; m_locked = 0; m_first = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("cyc_trim_code", trim_code, m_code, 0);
      chk("cyc_trim", trim, m_trim, 0);
      chk("cyc_locked", locked, m_locked, 0);
      chk("cyc_ref_lost", ref_lost, m_ref_lost, 0);
      chk("cyc_count_last", count_last, m_count_last, 0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic periods(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      osc = 1'b1;
      cycles(p / 2);
      osc = 1'b0;
      cycles(p - p / 2);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; osc = 1'b0; div = 5'd8; mode = 2'b00; ext_trim = '0;
    cycles(3);
    reset = 1'b0;
    chk("rst_code", trim_code, 13, 1);
    chk("rst_trim", trim, 26'h0001FFF, 1);
    chk("rst_locked", locked, 0, 1);
    chk("rst_ref_lost", ref_lost, 0, 1);
    chk("rst_count_last", count_last, 0, 1);

    // Slow reference: 12 cycles against div 8, code climbs after first discarded edge
    periods(12, 6);
    chk("climb_code", trim_code, 18, 1);
    chk("climb_trim", trim, 26'h003FFFF, 1);
    chk("climb_count", count_last, 12, 1);
    chk("climb_locked", locked, 0, 1);

    div = 5'd20;
    periods(2, 30);
    chk("sat_lo_code", trim_code, 0, 1);
    chk("sat_lo_trim", trim, 0, 1);
    chk("sat_lo_count", count_last, 2, 1);

    div = 5'd5;
    periods(30, 30);
    chk("sat_hi_code", trim_code, 26, 1);
    chk("sat_hi_trim", trim, 26'h3FFFFFF, 1);
    chk("sat_hi_count", count_last, 30, 1);

    // Closed loop: period follows the code as 4 + code/2
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    div = 5'd10;
    for (int k = 0; k < 4; k++) periods(4 + m_code / 2, 1);
    chk("cl_not_yet_locked", locked, 0, 1);
    periods(4 + m_code / 2, 1);
    chk("cl_locked", locked, 1, 1);
    chk("cl_code", trim_code, 13, 1);
    periods(14, 1);
    periods(4 + m_code / 2, 1);
    chk("cl_unlock", locked, 0, 1);
    chk("cl_code_up", trim_code, 14, 1);
    chk("cl_count", count_last, 14, 1);

    ext_trim = 26'h2AAAAAA;
    mode = 2'b01;
    cycles(2);
    chk("ext_trim", trim, 26'h2AAAAAA, 1);
    periods(14, 3);
    chk("ext_code_frozen", trim_code, 14, 1);
    chk("ext_count", count_last, 14, 1);
    mode = 2'b00;
    cycles(1);
    chk("ext_back_therm", trim, 26'h0003FFF, 1);

    cycles(300);
    chk("lost_flag", ref_lost, 1, 1);
    chk("lost_locked", locked, 0, 1);
    periods(16, 1);
    chk("lost_cleared", ref_lost, 0, 1);
    chk("lost_first_edge_code", trim_code, 14, 1);
    periods(10, 1);
    chk("lost_second_edge_code", trim_code, 15, 1);

    periods(11, 6);
    chk("en_locked", locked, 1, 1);
    osc = 1'b1;
    cycles(5);
    osc = 1'b0;
    enable = 1'b0;
    cycles(10);
    chk("dis_locked", locked, 0, 1);
    chk("dis_code", trim_code, 15, 1);
    chk("dis_count", count_last, 11, 1);
    enable = 1'b1;
    periods(20, 1);
    chk("reen_discard_code", trim_code, 15, 1);
    periods(20, 1);
    chk("reen_meas_code", trim_code, 16, 1);
    chk("reen_meas_count", count_last, 20, 1);

    cycles(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
